// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one external memory bus between the instruction cache
// refill port (F) and the data cache refill/writeback port (M).
//  - One owner per tenure. The grant is held until the owner drops its request.
//    There is no preemption.
//  - When both ports request from IDLE, the port that did not own the bus last wins.
//  - The owner's address and write data are muxed onto the bus. BusReady is gated
//    back to the owner only.
//  - BeatCount is the refill word offset. It wraps modulo blocksize.
// Ports:
//  clk, reset                    clock, synchronous active-high reset
//  HRequestF, HAddrF             instruction cache request / address
//  HRequestM, HAddrM,
//  HWriteM, HWDataM              data cache request / address / write / write data
//  BusReady                      memory finished the current beat this cycle
//  HRequest, HAddr,
//  HWrite, HWData                bus-side request/address/write/data of the current owner
//  GrantF, GrantM                registered ownership flags
//  BusReadyF, BusReadyM          BusReady gated by ownership
//  BeatCount                     beats completed in the current tenure, mod blocksize
//  LastBeat                      the final beat of a block completes this cycle
module mem_bus_arbiter #(
  parameter int unsigned blocksize = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         HRequestF,
  input  logic [31:0]                  HAddrF,
  input  logic                         HRequestM,
  input  logic [31:0]                  HAddrM,
  input  logic                         HWriteM,
  input  logic [31:0]                  HWDataM,
  input  logic                         BusReady,
  output logic                         HRequest,
  output logic [31:0]                  HAddr,
  output logic                         HWrite,
  output logic [31:0]                  HWData,
  output logic                         GrantF,
  output logic                         GrantM,
  output logic                         BusReadyF,
  output logic                         BusReadyM,
  output logic [$clog2(blocksize)-1:0] BeatCount,
  output logic                         LastBeat
);

  localparam int unsigned beat_w = $clog2(blocksize);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_F = 2'd1,
    OWN_M = 2'd2
  } state_t;

  state_t            state;
  state_t            next_state;
  logic              last_owner_m;  // 1: M owned the bus last, 0: F (reset value)
  logic              next_last_owner_m;
  logic [beat_w-1:0] beat_count;
  logic              owned;

  // Next-owner decision. A handover between owners skips IDLE.
  always_comb begin
    next_state        = state;
    next_last_owner_m = last_owner_m;
    case (state)
      IDLE: begin
        if (HRequestF && HRequestM) begin
          next_state = last_owner_m ? OWN_F : OWN_M;
        end else if (HRequestF) begin
          next_state = OWN_F;
        end else if (HRequestM) begin
          next_state = OWN_M;
        end
      end
      OWN_F: begin
        if (!HRequestF) begin
          next_last_owner_m = 1'b0;
          next_state        = HRequestM ? OWN_M : IDLE;
        end
      end
      OWN_M: begin
        if (!HRequestM) begin
          next_last_owner_m = 1'b1;
          next_state        = HRequestF ? OWN_F : IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State, last-owner and beat counter registers.
  // The counter restarts on every ownership change. Otherwise it counts BusReady
  // while the bus is owned and wraps naturally at blocksize.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      last_owner_m <= 1'b0;
      beat_count   <= '0;
    end else begin
      state        <= next_state;
      last_owner_m <= next_last_owner_m;
      if (next_state != state) begin
        beat_count <= '0;
      end else if (BusReady && owned) begin
        beat_count <= beat_count + beat_w'(1);
      end
    end
  end

  assign owned  = (state == OWN_F) || (state == OWN_M);
  assign GrantF = (state == OWN_F);
  assign GrantM = (state == OWN_M);

  // Bus-side mux. Everything is zero while IDLE.
  always_comb begin
    HRequest = 1'b0;
    HAddr    = 32'h0;
    HWrite   = 1'b0;
    HWData   = 32'h0;
    case (state)
      OWN_F: begin
        HRequest = HRequestF;
        HAddr    = HAddrF;
      end
      OWN_M: begin
        HRequest = HRequestM;
        HAddr    = HAddrM;
        HWrite   = HWriteM;
        HWData   = HWDataM;
      end
      default: begin
        HRequest = 1'b0;
      end
    endcase
  end

  // A beat that completes in the same cycle the owner drops its request
  // still counts toward the gated ready and LastBeat.
  assign BusReadyF = BusReady & GrantF;
  assign BusReadyM = BusReady & GrantM;
  assign BeatCount = beat_count;
  assign LastBeat  = BusReady & owned & (beat_count == beat_w'(blocksize - 1));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter (blocksize = 4).
module tb_mem_bus_arbiter;

  logic        clk;
  logic        reset;
  logic        HRequestF;
  logic [31:0] HAddrF;
  logic        HRequestM;
  logic [31:0] HAddrM;
  logic        HWriteM;
  logic [31:0] HWDataM;
  logic        BusReady;
  logic        HRequest;
  logic [31:0] HAddr;
  logic        HWrite;
  logic [31:0] HWData;
  logic        GrantF;
  logic        GrantM;
  logic        BusReadyF;
  logic        BusReadyM;
  logic [1:0]  BeatCount;
  logic        LastBeat;

  int total;
  int bad;

  mem_bus_arbiter #(.blocksize(4)) dut (
    .clk(clk), .reset(reset),
    .HRequestF(HRequestF), .HAddrF(HAddrF),
    .HRequestM(HRequestM), .HAddrM(HAddrM), .HWriteM(HWriteM), .HWDataM(HWDataM),
    .BusReady(BusReady),
    .HRequest(HRequest), .HAddr(HAddr), .HWrite(HWrite), .HWData(HWData),
    .GrantF(GrantF), .GrantM(GrantM),
    .BusReadyF(BusReadyF), .BusReadyM(BusReadyM),
    .BeatCount(BeatCount), .LastBeat(LastBeat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 2 time units past it.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    HRequestF = 1'b0;
    HRequestM = 1'b0;
    HWriteM   = 1'b0;
    BusReady  = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    HAddrF  = 32'h0000_0100;
    HAddrM  = 32'h0000_0200;
    HWDataM = 32'h1234_5678;
    do_reset();
    total++; if (GrantF !== 1'b0) begin bad++; $display("FAIL reset_grant_f got=%b exp=0", GrantF); end
    total++; if (GrantM !== 1'b0) begin bad++; $display("FAIL reset_grant_m got=%b exp=0", GrantM); end
    total++; if (HAddr !== 32'h0) begin bad++; $display("FAIL reset_haddr got=%h exp=0", HAddr); end
    total++; if (HWData !== 32'h0) begin bad++; $display("FAIL reset_hwdata got=%h exp=0", HWData); end
    total++; if (BeatCount !== 2'd0) begin bad++; $display("FAIL reset_beat got=%0d exp=0", BeatCount); end
    // BusReady is ignored while IDLE.
    BusReady = 1'b1;
    #1;
    total++; if ({BusReadyF, BusReadyM, LastBeat} !== 3'b000) begin bad++; $display("FAIL idle_ready got=%b exp=000", {BusReadyF, BusReadyM, LastBeat}); end
    step();
    total++; if (BeatCount !== 2'd0) begin bad++; $display("FAIL idle_beat_hold got=%0d exp=0", BeatCount); end
    BusReady = 1'b0;
  endtask

  // Covers the single-F grant and the beat counter over one full block.
  task automatic test_f_tenure();
    do_reset();
    HAddrF    = 32'h0000_0100;
    HRequestF = 1'b1;
    #1;
    total++; if (GrantF !== 1'b0 || HRequest !== 1'b0) begin bad++; $display("FAIL f_grant_early got=%b%b exp=00", GrantF, HRequest); end
    step();
    total++; if (GrantF !== 1'b1 || GrantM !== 1'b0) begin bad++; $display("FAIL f_grant got=%b%b exp=10", GrantF, GrantM); end
    total++; if (HAddr !== 32'h100 || HWrite !== 1'b0 || HRequest !== 1'b1) begin bad++; $display("FAIL f_bus got=%h/%b/%b exp=100/0/1", HAddr, HWrite, HRequest); end
    for (int i = 0; i < 4; i++) begin
      BusReady = 1'b1;
      #1;
      total++; if (BeatCount !== 2'(i)) begin bad++; $display("FAIL f_beat_%0d got=%0d exp=%0d", i, BeatCount, i); end
      total++; if (LastBeat !== (i == 3)) begin bad++; $display("FAIL f_last_%0d got=%b exp=%b", i, LastBeat, (i == 3)); end
      total++; if (BusReadyF !== 1'b1 || BusReadyM !== 1'b0) begin bad++; $display("FAIL f_ready_%0d got=%b%b exp=10", i, BusReadyF, BusReadyM); end
      step();
      BusReady = 1'b0;
      #1;
      total++; if (LastBeat !== 1'b0) begin bad++; $display("FAIL f_last_idle_%0d got=%b exp=0", i, LastBeat); end
    end
    total++; if (BeatCount !== 2'd0) begin bad++; $display("FAIL f_wrap got=%0d exp=0", BeatCount); end
    HRequestF = 1'b0;
    step();
    total++; if (GrantF !== 1'b0 || HAddr !== 32'h0) begin bad++; $display("FAIL f_release got=%b/%h exp=0/0", GrantF, HAddr); end
  endtask

  // Covers both-request arbitration and back-to-back handover without IDLE.
  task automatic test_back_to_back();
    do_reset();
    HAddrF    = 32'h0000_0100;
    HAddrM    = 32'h0000_0200;
    HRequestF = 1'b1;
    HRequestM = 1'b1;
    step();
    total++; if (GrantM !== 1'b1 || GrantF !== 1'b0 || HAddr !== 32'h200) begin bad++; $display("FAIL b2b_first_m got=%b%b/%h exp=01/200", GrantF, GrantM, HAddr); end
    HRequestM = 1'b0;
    #1;
    total++; if (HRequest !== 1'b0) begin bad++; $display("FAIL b2b_hreq_drop got=%b exp=0", HRequest); end
    step();
    total++; if (GrantF !== 1'b1 || GrantM !== 1'b0 || HAddr !== 32'h100) begin bad++; $display("FAIL b2b_handover got=%b%b/%h exp=10/100", GrantF, GrantM, HAddr); end
    HRequestF = 1'b0;
    step();
    total++; if (GrantF !== 1'b0 || GrantM !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b%b exp=00", GrantF, GrantM); end
    HRequestF = 1'b1;
    HRequestM = 1'b1;
    step();
    total++; if (GrantM !== 1'b1 || GrantF !== 1'b0) begin bad++; $display("FAIL b2b_m_after_f got=%b%b exp=01", GrantF, GrantM); end
    // M releases to IDLE, so the next tie goes to F.
    HRequestF = 1'b0;
    HRequestM = 1'b0;
    step();
    HRequestF = 1'b1;
    HRequestM = 1'b1;
    step();
    total++; if (GrantF !== 1'b1 || GrantM !== 1'b0) begin bad++; $display("FAIL b2b_f_after_m got=%b%b exp=10", GrantF, GrantM); end
    HRequestF = 1'b0;
    HRequestM = 1'b0;
    step();
  endtask

  // Covers no preemption, a beat in the drop cycle, and write muxing.
  task automatic test_no_preempt_write();
    do_reset();
    HAddrF    = 32'h0000_0100;
    HAddrM    = 32'h0000_0200;
    HRequestM = 1'b1;
    step();
    HRequestF = 1'b1;
    BusReady  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (GrantM !== 1'b1 || GrantF !== 1'b0) begin bad++; $display("FAIL np_hold_%0d got=%b%b exp=01", i, GrantF, GrantM); end
      total++; if (BusReadyF !== 1'b0 || BusReadyM !== 1'b1) begin bad++; $display("FAIL np_ready_%0d got=%b%b exp=01", i, BusReadyF, BusReadyM); end
      total++; if (BeatCount !== 2'(i)) begin bad++; $display("FAIL np_beat_%0d got=%0d exp=%0d", i, BeatCount, i); end
      step();
    end
    HRequestM = 1'b0;
    #1;
    total++; if (BusReadyM !== 1'b1 || LastBeat !== 1'b1) begin bad++; $display("FAIL np_drop_beat got=%b%b exp=11", BusReadyM, LastBeat); end
    step();
    total++; if (GrantF !== 1'b1 || BeatCount !== 2'd0 || BusReadyF !== 1'b1) begin bad++; $display("FAIL np_to_f got=%b/%0d/%b exp=1/0/1", GrantF, BeatCount, BusReadyF); end
    BusReady = 1'b0;
    HWriteM  = 1'b1;
    HWDataM  = 32'hDEAD_BEEF;
    #1;
    total++; if (HWrite !== 1'b0 || HWData !== 32'h0) begin bad++; $display("FAIL wr_in_f got=%b/%h exp=0/0", HWrite, HWData); end
    HRequestF = 1'b0;
    HRequestM = 1'b1;
    step();
    total++; if (GrantM !== 1'b1 || HWrite !== 1'b1 || HWData !== 32'hDEAD_BEEF || HAddr !== 32'h200) begin bad++; $display("FAIL wr_in_m got=%b/%b/%h/%h exp=1/1/deadbeef/200", GrantM, HWrite, HWData, HAddr); end
    HRequestM = 1'b0;
    HWriteM   = 1'b0;
    step();
  endtask

  // Covers reset asserted in the middle of a tenure.
  task automatic test_mid_reset();
    do_reset();
    HAddrF    = 32'h0000_0100;
    HRequestF = 1'b1;
    step();
    BusReady = 1'b1;
    step();
    step();
    total++; if (BeatCount !== 2'd2 || GrantF !== 1'b1) begin bad++; $display("FAIL mr_pre got=%0d/%b exp=2/1", BeatCount, GrantF); end
    reset = 1'b1;
    step();
    total++; if (GrantF !== 1'b0 || GrantM !== 1'b0 || HRequest !== 1'b0 || HAddr !== 32'h0) begin bad++; $display("FAIL mr_out got=%b%b%b/%h exp=000/0", GrantF, GrantM, HRequest, HAddr); end
    total++; if (BeatCount !== 2'd0 || BusReadyF !== 1'b0 || LastBeat !== 1'b0) begin bad++; $display("FAIL mr_beat got=%0d/%b/%b exp=0/0/0", BeatCount, BusReadyF, LastBeat); end
    reset     = 1'b0;
    BusReady  = 1'b0;
    HRequestF = 1'b0;
    step();
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    HRequestF = 1'b0;
    HAddrF    = 32'h0;
    HRequestM = 1'b0;
    HAddrM    = 32'h0;
    HWriteM   = 1'b0;
    HWDataM   = 32'h0;
    BusReady  = 1'b0;
    test_reset();
    test_f_tenure();
    test_back_to_back();
    test_no_preempt_write();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
